c_lock_rr_arbiter: RTL and testbench



---
 rtl/c_lock_rr_arbiter_pkg.sv | 10 +
 rtl/c_rr_select.sv | 43 ++++
 rtl/c_lock_rr_arbiter.sv | 92 +++++++++
 tb/tb_c_lock_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c_lock_rr_arbiter_pkg.sv
// Shared state encodings for the lock round-robin arbiter.
package c_lock_rr_arbiter_pkg;

    // Packet-lock FSM: IDLE arbitrates round-robin, LOCKED holds one owner.
    typedef enum logic [0:0] {
        CLRA_STATE_IDLE   = 1'b0,
        CLRA_STATE_LOCKED = 1'b1
    } clra_state_e;

endpackage

// File: rtl/c_rr_select.sv
// Wrap-around priority picker: first requester at or after the one-hot prio
// position, wrapping past the last port back to port 0.
module c_rr_select #(
    parameter int num_ports = 4
) (
    input  logic [0:num_ports-1] prio,
    input  logic [0:num_ports-1] req,
    output logic [0:num_ports-1] sel
);

    logic [0:num_ports-1]   therm;
    logic [0:2*num_ports-1] dbl;

    // Thermometer mask: ones from the priority port to the end of the vector.
    always_comb begin
        therm    = '0;
        therm[0] = prio[0];
        for (int i = 1; i < num_ports; i++) begin
            therm[i] = therm[i-1] | prio[i];
        end
    end

    // Left half holds requests at/after prio, right half the wrapped-around copy.
    assign dbl = {req & therm, req};

    // Pick the leftmost set bit of the doubled vector and fold it back.
    always_comb begin
        logic found;
        found = 1'b0;
        sel   = '0;
        for (int j = 0; j < 2*num_ports; j++) begin
            if (dbl[j] && !found) begin
                found = 1'b1;
                if (j < num_ports) begin
                    sel[j] = 1'b1;
                end else begin
                    sel[j-num_ports] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/c_lock_rr_arbiter.sv
// Round-robin arbiter that keeps a grant locked to one port until that
// port's tail request is granted, keeping packets atomic.
module c_lock_rr_arbiter
    import c_lock_rr_arbiter_pkg::*;
#(
    parameter int num_ports = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic [0:num_ports-1] req,
    input  logic [0:num_ports-1] tail,
    output logic [0:num_ports-1] gnt,
    output logic                 gnt_valid,
    output logic                 locked
);

    clra_state_e          state_q, state_d;
    logic [0:num_ports-1] prio_q, prio_d;
    logic [0:num_ports-1] lock_q, lock_d;
    logic [0:num_ports-1] rr_gnt;
    logic                 gnt_tail;

    c_rr_select #(
        .num_ports(num_ports)
    ) u_select (
        .prio(prio_q),
        .req (req),
        .sel (rr_gnt)
    );

    // While locked only the owner may win; otherwise take the round-robin pick.
    always_comb begin
        gnt = rr_gnt;
        if (state_q == CLRA_STATE_LOCKED) begin
            gnt = lock_q & req;
        end
    end

    assign gnt_valid = |gnt;
    assign gnt_tail  = |(gnt & tail);
    assign locked    = (state_q == CLRA_STATE_LOCKED);

    // Next-state logic: lock on a non-tail win, release on the owner's tail,
    // and move priority just past the winner of every idle arbitration.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        lock_d  = lock_q;
        if (active) begin
            case (state_q)
                CLRA_STATE_IDLE: begin
                    if (gnt_valid) begin
                        for (int i = 0; i < num_ports; i++) begin
                            prio_d[(i+1) % num_ports] = gnt[i];
                        end
                        if (!gnt_tail) begin
                            state_d = CLRA_STATE_LOCKED;
                            lock_d  = gnt;
                        end
                    end
                end
                CLRA_STATE_LOCKED: begin
                    if (gnt_valid && gnt_tail) begin
                        state_d = CLRA_STATE_IDLE;
                        lock_d  = '0;
                    end
                end
                default: begin
                    state_d = CLRA_STATE_IDLE;
                    lock_d  = '0;
                end
            endcase
        end
    end

    // State registers; reset drops any lock immediately, even mid-packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLRA_STATE_IDLE;
            prio_q  <= {1'b1, {(num_ports-1){1'b0}}};
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            lock_q  <= lock_d;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

endmodule

// File: tb/tb_c_lock_rr_arbiter.sv
// Self-checking bench: directed packet scenarios plus randomized traffic
// compared against a port-number level reference model.
module tb_c_lock_rr_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         active;
    logic [0:N-1] req;
    logic [0:N-1] tail;
    logic [0:N-1] gnt;
    logic         gnt_valid;
    logic         locked;

    logic [0:0]   req1;
    logic [0:0]   tail1;
    logic [0:0]   gnt1;
    logic         gnt_valid1;
    logic         locked1;

    int checkCount = 0;
    int failCount  = 0;

    bit mLocked;
    int mOwner;
    int mPrio;

    c_lock_rr_arbiter #(.num_ports(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .active   (active),
        .req      (req),
        .tail     (tail),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .locked   (locked)
    );

    c_lock_rr_arbiter #(.num_ports(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .active   (active),
        .req      (req1),
        .tail     (tail1),
        .gnt      (gnt1),
        .gnt_valid(gnt_valid1),
        .locked   (locked1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Winning port number under the model, or -1 when nobody wins.
    function automatic int modelWinner();
        if (mLocked) return req[mOwner] ? mOwner : -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (mPrio + k) % N;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [0:N-1] toMask(input int p);
        logic [0:N-1] m;
        m = '0;
        if (p >= 0) m[p] = 1'b1;
        return m;
    endfunction

    task automatic modelReset();
        mLocked = 1'b0;
        mOwner  = 0;
        mPrio   = 0;
    endtask

    task automatic modelEdge();
        int w;
        if (!active) return;
        w = modelWinner();
        if (!mLocked) begin
            if (w >= 0) begin
                mPrio = (w + 1) % N;
                if (!tail[w]) begin
                    mLocked = 1'b1;
                    mOwner  = w;
                end
            end
        end else if (w >= 0 && tail[w]) begin
            mLocked = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge and compare against the model.
    task automatic applyStimulus(input logic [0:N-1] r, input logic [0:N-1] t, input logic a);
        logic [0:N-1] expGnt;
        req    = r;
        tail   = t;
        active = a;
        #1;
        expGnt = toMask(modelWinner());
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        checkOutput("gnt_valid", 32'(gnt_valid), 32'(|expGnt));
        checkOutput("locked", 32'(locked), 32'(mLocked));
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        active = 1'b1;
        req    = 4'b0101;
        tail   = 4'b1111;
        req1   = 1'b0;
        tail1  = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'(4'b0100));
        checkOutput("rst_locked", 32'(locked), 32'(1'b0));
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] fairness after reset");
        applyStimulus(4'b0101, 4'b1111, 1'b1);
        checkOutput("fair0", 32'(gnt), 32'(4'b0100));
        endCycle();
        applyStimulus(4'b0101, 4'b1111, 1'b1);
        checkOutput("fair1", 32'(gnt), 32'(4'b0001));
        endCycle();
        applyStimulus(4'b0101, 4'b1111, 1'b1);
        checkOutput("fair2", 32'(gnt), 32'(4'b0100));
        checkOutput("fair_locked", 32'(locked), 32'(1'b0));
        endCycle();

        $display("[TB] lock hold");
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        checkOutput("hold0", 32'(gnt), 32'(4'b0010));
        endCycle();
        applyStimulus(4'b1010, 4'b0000, 1'b1);
        checkOutput("hold1", 32'(gnt), 32'(4'b0010));
        checkOutput("hold1_locked", 32'(locked), 32'(1'b1));
        endCycle();
        applyStimulus(4'b1010, 4'b0010, 1'b1);
        checkOutput("hold2", 32'(gnt), 32'(4'b0010));
        endCycle();
        applyStimulus(4'b1010, 4'b1111, 1'b1);
        checkOutput("hold3", 32'(gnt), 32'(4'b1000));
        checkOutput("hold3_locked", 32'(locked), 32'(1'b0));
        endCycle();

        $display("[TB] locked bubble");
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        endCycle();
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        checkOutput("bubble_gnt", 32'(gnt), 32'(4'b0000));
        checkOutput("bubble_valid", 32'(gnt_valid), 32'(1'b0));
        checkOutput("bubble_locked", 32'(locked), 32'(1'b1));
        endCycle();
        applyStimulus(4'b1100, 4'b0100, 1'b1);
        checkOutput("bubble_tail", 32'(gnt), 32'(4'b0100));
        endCycle();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("bubble_unlock", 32'(locked), 32'(1'b0));
        endCycle();

        $display("[TB] freeze");
        applyStimulus(4'b0001, 4'b1111, 1'b1);
        endCycle();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        checkOutput("freeze_gnt", 32'(gnt), 32'(4'b0010));
        endCycle();
        applyStimulus(4'b1010, 4'b1111, 1'b1);
        checkOutput("freeze_after", 32'(gnt), 32'(4'b1000));
        checkOutput("freeze_locked", 32'(locked), 32'(1'b0));
        endCycle();

        $display("[TB] async reset mid-packet");
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        endCycle();
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        checkOutput("pre_rst_locked", 32'(locked), 32'(1'b1));
        endCycle();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_locked", 32'(locked), 32'(1'b0));
        req  = 4'b1001;
        tail = 4'b1111;
        #1;
        checkOutput("async_gnt", 32'(gnt), 32'(4'b1000));
        reset = 1'b0;
        applyStimulus(4'b1001, 4'b1111, 1'b1);
        checkOutput("post_rst_gnt", 32'(gnt), 32'(4'b1000));
        endCycle();

        $display("[TB] random traffic");
        for (int it = 0; it < 400; it++) begin
            logic [0:N-1] r;
            logic [0:N-1] t;
            r = 4'($urandom_range(0, 15));
            t = 4'($urandom_range(0, 15));
            applyStimulus(r, t, ($urandom_range(0, 7) != 0));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1;
                modelReset();
                checkOutput("rand_rst_locked", 32'(locked), 32'(1'b0));
                #1;
                reset = 1'b0;
            end
            endCycle();
        end

        $display("[TB] single port");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        endCycle();
        req1  = 1'b1;
        tail1 = 1'b0;
        #1;
        checkOutput("one_gnt", 32'(gnt1), 32'(1'b1));
        checkOutput("one_unlocked", 32'(locked1), 32'(1'b0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("one_locked", 32'(locked1), 32'(1'b1));
        tail1 = 1'b1;
        #1;
        checkOutput("one_tail_gnt", 32'(gnt1), 32'(1'b1));
        @(posedge clk);
        @(negedge clk);
        checkOutput("one_release", 32'(locked1), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
